mac_result_fifo: RTL and testbench

//  Downstream stage of the mac unit: captures every mac_out word qualified by out_valid and

---
 rtl/mac_result_fifo_if.sv | 26 ++
 rtl/mac_result_fifo.sv | 70 +++++++
 tb/tb_mac_result_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mac_result_fifo_if.sv
// Push and read-port bundle between the mac result FIFO and its neighbours.
// The mac side drives the write strobe, and the consumer side drives the read handshake.
interface mac_result_fifo_if #(
  parameter int DW = 11,
  parameter int AW = 4
);
  logic [DW-1:0] mac_in;
  logic          mac_in_valid;
  logic          rd_ready;
  logic          clr_ovf;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  modport master (
    output mac_in, mac_in_valid, rd_ready, clr_ovf,
    input  rd_data, rd_valid, count, full, overflow
  );

  modport slave (
    input  mac_in, mac_in_valid, rd_ready, clr_ovf,
    output rd_data, rd_valid, count, full, overflow
  );
endinterface

// File: rtl/mac_result_fifo.sv
// Show-ahead result FIFO behind the mac. It never stalls the mac: when the FIFO is full,
// a word arriving with no pop in the same cycle is dropped and the sticky overflow flag is set.
module mac_result_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  mac_result_fifo_if.slave  bus
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic not_empty;
  logic is_full;
  logic pop;
  logic push;
  logic drop;

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == FULL_COUNT);
  assign pop       = not_empty & bus.rd_ready;
  // A pop frees a slot in the same edge, so a full FIFO still accepts a word while draining.
  assign push      = bus.mac_in_valid & (~is_full | pop);
  assign drop      = bus.mac_in_valid & ~push;

  // NOTE: the storage array is deliberately left without a reset; it is only observable
  // through rd_data while count != 0, and the entries are always written before they are read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.mac_in;
  end

  // NOTE: all sequential state uses non-blocking assignments, so every register samples the
  // pre-edge values of push/pop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase

      // A drop in the same cycle as a clear wins, so no loss event is ever lost.
      if (drop)             overflow_q <= 1'b1;
      else if (bus.clr_ovf) overflow_q <= 1'b0;
    end
  end

  assign bus.rd_data  = not_empty ? mem[rd_ptr] : '0;
  assign bus.rd_valid = not_empty;
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Scoreboard bench for mac_result_fifo. The stimulus tasks queue the expected words, and a
// negedge monitor compares occupancy, flags and the head word on every cycle.
module tb_mac_result_fifo;

  localparam int DW    = 11;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mac_result_fifo_if #(.DW(DW), .AW(AW)) bus ();

  mac_result_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] exp_q[$];
  logic          exp_ovf;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic pop_i, acc, drp;
    bus.mac_in_valid = v;
    bus.mac_in       = v ? d : 11'h555;
    bus.rd_ready     = rdy;
    bus.clr_ovf      = clr;
    pop_i = rdy && (exp_q.size() != 0);
    acc   = v && ((exp_q.size() < DEPTH) || pop_i);
    drp   = v && !acc;
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(d);
    if (drp)      exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      k++;
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("drain_count_zero", 32'(bus.count), 32'd0);
    check("drain_rd_valid_low", 32'(bus.rd_valid), 32'd0);
  endtask

  // The monitor checks the DUT against the model state while reset is released.
  always @(negedge clk) begin
    if (reset) begin
      check("count", 32'(bus.count), 32'(exp_q.size()));
      check("rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() != 0));
      check("full", 32'(bus.full), 32'(exp_q.size() == DEPTH));
      check("overflow", 32'(bus.overflow), 32'(exp_ovf));
      if (exp_q.size() != 0) begin
        check("rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
        if (bus.rd_ready) void'(exp_q.pop_front());
      end else begin
        check("rd_data_empty", 32'(bus.rd_data), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] t2_vec [10] = '{11'd5, 11'd17, 11'd100, 11'd255, 11'd333,
                                 11'd512, 11'd700, 11'd901, 11'd1023, 11'd1200};

  initial begin
    exp_ovf          = 1'b0;
    reset            = 1'b0;
    bus.mac_in       = '0;
    bus.mac_in_valid = 1'b0;
    bus.rd_ready     = 1'b0;
    bus.clr_ovf      = 1'b0;
    #2;
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_full", 32'(bus.full), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data), 32'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    // T2: ten-word mac stream, buffered and then read back in order
    foreach (t2_vec[i]) cycle(1'b1, t2_vec[i], 1'b0, 1'b0);
    check("t2_count_10", 32'(bus.count), 32'd10);
    drain();

    // T3: seventeen pushes into sixteen entries, so word 17 is dropped
    for (int i = 1; i <= 17; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_count_16", 32'(bus.count), 32'd16);
    check("t3_overflow", 32'(bus.overflow), 32'd1);

    // T4: at full, a push with a simultaneous pop is accepted
    cycle(1'b1, 11'h7FF, 1'b1, 1'b0);
    check("t4_count_16", 32'(bus.count), 32'd16);
    check("t4_overflow_held", 32'(bus.overflow), 32'd1);
    check("t4_head_is_2", 32'(bus.rd_data), 32'd2);
    drain();

    // T1: an asynchronous reset with data queued takes effect without a clock edge
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0);
    bus.mac_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t1_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("t1_count", 32'(bus.count), 32'd0);
    check("t1_full", 32'(bus.full), 32'd0);
    check("t1_overflow", 32'(bus.overflow), 32'd0);
    check("t1_rd_data", 32'(bus.rd_data), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_no_glitch_word", 32'(bus.rd_valid), 32'd0);

    // T6: a drop in the same cycle as clr_ovf keeps the flag set; clr_ovf alone clears it
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(300 + i), 1'b0, 1'b0);
    cycle(1'b1, 11'd999, 1'b0, 1'b1);
    check("t6_set_beats_clear", 32'(bus.overflow), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t6_cleared", 32'(bus.overflow), 32'd0);
    drain();

    // T5: forty words with a mixed push/pop pattern; the write pointer wraps twice
    begin
      int pushed = 0;
      int it = 0;
      logic v, r;
      while (pushed < 40 && it < 400) begin
        v = 1'($urandom_range(0, 3) != 0);
        r = (it < 30) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
        if (exp_q.size() == DEPTH && !r) v = 1'b0;
        cycle(v, DW'(pushed * 37 + 3), r, 1'b0);
        if (v) pushed++;
        it++;
      end
      check("t5_all_pushed", 32'(pushed), 32'd40);
    end
    drain();
    check("t5_no_overflow", 32'(bus.overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
